// File: rtl/seq_div_32bit.sv
// Multi-cycle restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Optional macro SEQ_DIV_SIGNED_EN adds signed_op for two's-complement division.
module seq_div_32bit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SEQ_DIV_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic             r_neg_q;
   logic             r_neg_r;

   logic             w_accept;
   logic             w_last;
   logic             w_dvs_zero;
   logic             w_sgn_dvd;
   logic             w_sgn_dvs;
   logic [WIDTH-1:0] w_mag_dvd;
   logic [WIDTH-1:0] w_mag_dvs;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_fits;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_quo_nx;

   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

`ifdef SEQ_DIV_SIGNED_EN
   assign w_sgn_dvd = signed_op & dividend[WIDTH-1];
   assign w_sgn_dvs = signed_op & divisor[WIDTH-1];
`else
   assign w_sgn_dvd = 1'b0;
   assign w_sgn_dvs = 1'b0;
`endif

   // Magnitudes are divided unsigned; signs are reapplied on the final step.
   assign w_mag_dvd  = f_neg(dividend, w_sgn_dvd);
   assign w_mag_dvs  = f_neg(divisor, w_sgn_dvs);
   assign w_dvs_zero = (divisor == '0);

   assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
   assign w_trial  = w_shift - {1'b0, r_dvs};
   assign w_fits   = ~w_trial[WIDTH];
   assign w_rem_nx = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nx = {r_dvd[WIDTH-2:0], w_fits};
   assign w_last   = (r_count == CNT_W'(WIDTH - 1));

   always_comb begin
      w_next   = r_state;
      busy     = 1'b0;
      done     = 1'b0;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = start;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            w_accept = start;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (w_accept) w_next = w_dvs_zero ? S_DONE : S_RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (w_accept) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_dvd       <= w_mag_dvd;
         r_dvs       <= w_mag_dvs;
         r_neg_q     <= w_sgn_dvd ^ w_sgn_dvs;
         r_neg_r     <= w_sgn_dvd;
         div_by_zero <= w_dvs_zero;
         if (w_dvs_zero) begin
            quotient  <= '1;
            remainder <= dividend;
         end
      end else if (r_state == S_RUN) begin
         r_count <= r_count + CNT_W'(1);
         r_rem   <= w_rem_nx;
         r_dvd   <= w_quo_nx;
         if (w_last) begin
            quotient  <= f_neg(w_quo_nx, r_neg_q);
            remainder <= f_neg(w_rem_nx, r_neg_r);
         end
      end
   end

endmodule

// File: tb/tb_seq_div_32bit.sv
// Directed bench for seq_div_32bit: vector table plus hand sequences for
// back-to-back, busy-ignore and asynchronous reset mid-operation.
module tb_seq_div_32bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
`ifdef SEQ_DIV_SIGNED_EN
   logic        signed_op = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   seq_div_32bit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef SEQ_DIV_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one start at the current negedge, waits for done, checks latency/results/hold.
   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      int cycles;
      int busy_cnt;
      int lat;
      lat      = (b == 0) ? 1 : 33;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = 32'h5555_AAAA;
      divisor  = 32'h0000_0003;
      cycles   = 1;
      busy_cnt = busy ? 1 : 0;
      while (!done && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (busy) busy_cnt++;
      end
      chk({name, " done"}, {31'd0, done}, 32'd1);
      chk({name, " latency"}, cycles, lat);
      chk({name, " busy cycles"}, busy_cnt, lat - 1);
      chk({name, " quotient"}, quotient, eq);
      chk({name, " remainder"}, remainder, er);
      chk({name, " dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
      @(negedge clk);
      chk({name, " done one cycle"}, {31'd0, done}, 32'd0);
      chk({name, " quotient held"}, quotient, eq);
      chk({name, " remainder held"}, remainder, er);
   endtask

   initial begin
      int cycles;
      int pulses;

      vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1] = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1};
      vecs[2] = '{32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15,         1'b0};
      vecs[3] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
      vecs[4] = '{32'h12345678,   32'd1,          32'h12345678,   32'd0,          1'b0};
      vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
      vecs[6] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
      vecs[7] = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0};
      vecs[8] = '{32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          1'b0};
      vecs[9] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle busy", {31'd0, busy}, 32'd0);
         chk("idle done", {31'd0, done}, 32'd0);
         chk("idle quotient", quotient, 32'd0);
         chk("idle remainder", remainder, 32'd0);
         chk("idle dbz", {31'd0, div_by_zero}, 32'd0);
      end

      for (int i = 0; i < 10; i++) begin
         run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
      end

      // Back-to-back with a start pulse mid-RUN that must be ignored.
      start    = 1'b1;
      dividend = 32'hFFFFFFFF;
      divisor  = 32'd16;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      repeat (9) begin @(negedge clk); cycles++; end
      start    = 1'b1;
      dividend = 32'd9;
      divisor  = 32'd3;
      @(negedge clk);
      cycles++;
      start = 1'b0;
      chk("b2b busy after ignored start", {31'd0, busy}, 32'd1);
      while (!done && cycles < 100) begin @(negedge clk); cycles++; end
      chk("b2b first latency", cycles, 33);
      chk("b2b first quotient", quotient, 32'h0FFFFFFF);
      chk("b2b first remainder", remainder, 32'd15);
      run_div("b2b second", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Asynchronous reset in the middle of a run.
      start    = 1'b1;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre-reset quotient", quotient, 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", {31'd0, busy}, 32'd0);
      chk("async rst done", {31'd0, done}, 32'd0);
      chk("async rst quotient", quotient, 32'd0);
      chk("async rst remainder", remainder, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("abandoned op activity", pulses, 0);
      run_div("after reset", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

`ifdef SEQ_DIV_SIGNED_EN
      signed_op = 1'b1;
      run_div("signed -7/2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      run_div("signed ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
      run_div("signed 7/-2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
      run_div("signed dbz", 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
      signed_op = 1'b0;
      run_div("unsigned via op0", 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
